operand_aligner: RTL
====================

Name: operand_aligner

Overview:
- Pre-add alignment stage of the floating-point adder datapath; the inverse operation of post-add normalization.
- Unpacks two IEEE-754 single-precision operands and orders them by magnitude.
- Right-shifts the smaller mantissa by the exponent difference, producing guard, round and sticky information.
- 2-stage valid/ready pipeline; output feeds the mantissa adder, whose result then goes to normalization.

Parameters:
- EXP_N, 8, exponent field width.
- FRAC_N, 23, stored fraction width; unpacked mantissa is FRAC_N+1 bits (hidden bit included).
- WIDTH, 32, packed operand width; must equal 1+EXP_N+FRAC_N.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- inValid  input  1  operand pair valid.
- inReady  output  1  aligner can accept an operand pair.
- opA  input  WIDTH  packed operand A.
- opB  input  WIDTH  packed operand B.
- outValid  output  1  aligned result valid.
- outReady  input  1  downstream accepts the result.
- bigExp  output  EXP_N  effective exponent of the larger-magnitude operand.
- bigMant  output  FRAC_N+1  larger mantissa, hidden bit at MSB.
- smallMant  output  FRAC_N+3  smaller mantissa with 2 appended zeros ({mant,2'b00}), shifted right (guard and round in the 2 LSBs).
- sticky  output  1  OR of all bits shifted past the LSB of smallMant.
- resultSign  output  1  sign of the larger-magnitude operand.
- effSub  output  1  signA XOR signB.
- swapped  output  1  B was the larger magnitude.
- special  output  1  either exponent field is all ones (Inf/NaN).

Behaviour:
- Reset values: outValid=0 and all data outputs 0; inReady=1 on the first cycle after reset is released.
- Reset asserted mid-operation drops both in-flight entries; no output is produced for them.
- Handshake:
  - A transfer occurs on any edge where valid&&ready.
  - Once outValid is asserted, outValid and all data outputs stay stable until outReady is seen.
- Pipeline:
  - Stage 1 register: unpack, compare, swap.
  - Stage 2 register: shift and sticky.
  - Latency is exactly 2 cycles at full throughput; sustains 1 transfer per cycle.
  - Stage 2 advances when !s2Valid || outReady.
  - Stage 1 advances when !s1Valid || stage 2 advances.
  - inReady = !s1Valid || stage 2 advances.
  - Holds 2 entries maximum; with outReady held low, inReady falls after 2 accepted pairs.
- Unpack:
  - Hidden bit = (exp != 0).
  - Effective exponent = exp, or 1 when exp == 0 (denormal).
- Ordering:
  - Big operand = larger effective exponent.
  - On equal exponents, big operand = larger mantissa.
  - On a full tie, A is big and swapped=0.
- Shift: diff = bigExp - smallExp (unsigned, EXP_N bits).
  - If diff >= FRAC_N+3: smallMant=0 and sticky = OR of the unshifted small mantissa.
  - Otherwise: smallMant = {mant,00} >> diff and sticky = OR of the bits shifted out.
- Special: when special=1, the shift is forced to 0 and sticky=0. Ordering, signs and mantissas are still produced; Inf/NaN resolution belongs downstream.
- Zero operands: hidden bit 0 and effective exponent 1, following the denormal rule; no special case.

Optional Feature:
- Macro: ALIGN_STATS_EN.
- When defined, adds two 16-bit outputs:
  - alignCount: increments on each output transfer.
  - shiftOutCount: increments on each output transfer whose diff >= FRAC_N+3.
- Both counters saturate at 16'hFFFF and clear on reset.
- When undefined, these ports and counters do not exist, and the rest of the behaviour is identical.

Test Plan:
- opA=0x3F800000 (1.0), opB=0x3F000000 (0.5), outReady=1 -> 2 cycles later: bigExp=127, bigMant=0x800000, smallMant=0x1000000, sticky=0, swapped=0, effSub=0.
- opA=0x3F800000, opB=0x4B800001 (diff 24) -> swapped=1, bigExp=151, bigMant=0x800001, smallMant=0x0000002, sticky=0.
- opA=0x3F800001, opB=0x4D000000 (diff 27) -> smallMant=0, sticky=1, swapped=1; with ALIGN_STATS_EN, shiftOutCount=1.
- opA=0x3F800000, opB=0xBFC00000 (-1.5, equal exponents) -> swapped=1, bigMant=0xC00000, smallMant=0x2000000, resultSign=1, effSub=1.
- Three back-to-back pairs offered with outReady=0 for 4 cycles:
  - inReady=0 after the 2nd acceptance.
  - outValid and data held stable while stalled.
  - After outReady=1, all 3 results appear in order with no loss.
- opA=0x7F800000 (Inf) with 1.0 -> special=1, sticky=0, smallMant={0x800000,00}.
- Reset pulsed while 2 entries are in flight -> outValid=0 the next cycle, inReady=1, and no stale result appears afterward.

Source files
------------

// File: rtl/operand_aligner.sv
// ---------------------------------------------------------------------------
// operand_aligner
//
// This is the pre-add alignment stage of the floating-point adder. It unpacks
// two IEEE-754 operands and orders them by magnitude. It then right-shifts the
// smaller mantissa by the exponent difference, so that the mantissa adder sees
// aligned operands that carry guard, round and sticky information.
//
// The block is a two-stage valid/ready pipeline:
//   stage 1 : unpack, magnitude compare, swap
//   stage 2 : alignment shift and sticky generation (drives the outputs)
//
// Optional build macro: ALIGN_STATS_EN
//   When it is defined, the block adds two saturating 16-bit counters:
//   alignCount and shiftOutCount.
//
// Ports
//   clock, reset       rising-edge clock, synchronous active-high reset
//   inValid / inReady  operand pair handshake
//   opA, opB           packed operands (WIDTH = 1 + EXP_N + FRAC_N)
//   outValid/outReady  result handshake; outputs hold while stalled
//   bigExp             effective exponent of the larger-magnitude operand
//   bigMant            larger mantissa, hidden bit at MSB
//   smallMant          {smaller mantissa, 2'b00} >> diff (guard/round in LSBs)
//   sticky             OR of bits shifted past the LSB of smallMant
//   resultSign         sign of the larger-magnitude operand
//   effSub             signA ^ signB
//   swapped            B was the larger magnitude
//   special            either exponent field is all ones (Inf/NaN)
//   alignCount         (ALIGN_STATS_EN) output transfers
//   shiftOutCount      (ALIGN_STATS_EN) output transfers with diff >= FRAC_N+3
// ---------------------------------------------------------------------------
module operand_aligner #(
    parameter int EXP_N  = 8,
    parameter int FRAC_N = 23,
    parameter int WIDTH  = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                inValid,
    output logic                inReady,
    input  logic [WIDTH-1:0]    opA,
    input  logic [WIDTH-1:0]    opB,
    output logic                outValid,
    input  logic                outReady,
    output logic [EXP_N-1:0]    bigExp,
    output logic [FRAC_N:0]     bigMant,
    output logic [FRAC_N+2:0]   smallMant,
    output logic                sticky,
    output logic                resultSign,
    output logic                effSub,
    output logic                swapped,
    output logic                special
`ifdef ALIGN_STATS_EN
    ,
    output logic [15:0]         alignCount,
    output logic [15:0]         shiftOutCount
`endif
);

    localparam int MANT_N = FRAC_N + 1;
    localparam int EXT_N  = FRAC_N + 3;
    localparam logic [EXP_N:0] SHIFT_LIMIT = (EXP_N+1)'(EXT_N);

    // ------------------------------------------------------------------
    // Unpack
    // ------------------------------------------------------------------
    logic              signA, signB;
    logic [EXP_N-1:0]  expA, expB;
    logic [EXP_N-1:0]  effA, effB;
    logic [MANT_N-1:0] mantA, mantB;
    logic              specialIn;
    logic              swapIn;

    always_comb begin
        signA = opA[WIDTH-1];
        signB = opB[WIDTH-1];
        expA  = opA[WIDTH-2 -: EXP_N];
        expB  = opB[WIDTH-2 -: EXP_N];
        // Denormals and zeros use exponent 1 with a clear hidden bit.
        effA  = (expA != '0) ? expA : EXP_N'(1);
        effB  = (expB != '0) ? expB : EXP_N'(1);
        mantA = {(expA != '0), opA[FRAC_N-1:0]};
        mantB = {(expB != '0), opB[FRAC_N-1:0]};
        specialIn = (&expA) | (&expB);
        // The {exp, mant} concatenation orders by exponent first and by
        // mantissa on a tie. On a full tie A stays big.
        swapIn = {effB, mantB} > {effA, mantA};
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1Valid, s2Valid;
    logic s1Advance, s2Advance;

    always_comb begin
        s2Advance = !s2Valid || outReady;
        s1Advance = !s1Valid || s2Advance;
        inReady   = s1Advance;
        outValid  = s2Valid;
    end

    // ------------------------------------------------------------------
    // Stage 1 register: ordered operands
    // ------------------------------------------------------------------
    logic [EXP_N-1:0]  s1BigExp, s1SmallExp;
    logic [MANT_N-1:0] s1BigMant, s1SmallMant;
    logic              s1Sign, s1EffSub, s1Swapped, s1Special;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1Valid     <= 1'b0;
            s1BigExp    <= '0;
            s1SmallExp  <= '0;
            s1BigMant   <= '0;
            s1SmallMant <= '0;
            s1Sign      <= 1'b0;
            s1EffSub    <= 1'b0;
            s1Swapped   <= 1'b0;
            s1Special   <= 1'b0;
        end else if (s1Advance) begin
            s1Valid <= inValid;
            if (inValid) begin
                s1BigExp    <= swapIn ? effB  : effA;
                s1SmallExp  <= swapIn ? effA  : effB;
                s1BigMant   <= swapIn ? mantB : mantA;
                s1SmallMant <= swapIn ? mantA : mantB;
                s1Sign      <= swapIn ? signB : signA;
                s1EffSub    <= signA ^ signB;
                s1Swapped   <= swapIn;
                s1Special   <= specialIn;
            end
        end
    end

    // ------------------------------------------------------------------
    // Alignment shift
    // ------------------------------------------------------------------
    logic [EXP_N-1:0] diff;
    logic [EXP_N-1:0] shAmt;
    logic             bigShift;
    logic [EXT_N-1:0] ext;
    logic [EXT_N-1:0] mask;
    logic [EXT_N-1:0] shMant;
    logic             shSticky;

    always_comb begin
        diff     = s1BigExp - s1SmallExp;
        bigShift = {1'b0, diff} >= SHIFT_LIMIT;
        // For Inf/NaN the shift is suppressed. Resolving them is left to
        // the downstream stages.
        shAmt    = s1Special ? '0 : diff;
        ext      = {s1SmallMant, 2'b00};
        mask     = '0;
        shMant   = '0;
        shSticky = 1'b0;
        if (bigShift && !s1Special) begin
            shMant   = '0;
            shSticky = |s1SmallMant;
        end else begin
            shMant   = ext >> shAmt;
            mask     = ~({EXT_N{1'b1}} << shAmt);
            shSticky = |(ext & mask);
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 register: outputs
    // ------------------------------------------------------------------
    logic s2BigShift;

    always_ff @(posedge clock) begin
        if (reset) begin
            s2Valid    <= 1'b0;
            bigExp     <= '0;
            bigMant    <= '0;
            smallMant  <= '0;
            sticky     <= 1'b0;
            resultSign <= 1'b0;
            effSub     <= 1'b0;
            swapped    <= 1'b0;
            special    <= 1'b0;
            s2BigShift <= 1'b0;
        end else if (s2Advance) begin
            s2Valid <= s1Valid;
            if (s1Valid) begin
                bigExp     <= s1BigExp;
                bigMant    <= s1BigMant;
                smallMant  <= shMant;
                sticky     <= shSticky;
                resultSign <= s1Sign;
                effSub     <= s1EffSub;
                swapped    <= s1Swapped;
                special    <= s1Special;
                s2BigShift <= bigShift;
            end
        end
    end

`ifdef ALIGN_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics counters
    // ------------------------------------------------------------------
    logic outXfer;
    assign outXfer = s2Valid && outReady;

    always_ff @(posedge clock) begin
        if (reset) begin
            alignCount    <= '0;
            shiftOutCount <= '0;
        end else if (outXfer) begin
            if (alignCount != '1)
                alignCount <= alignCount + 16'd1;
            if (s2BigShift && (shiftOutCount != '1))
                shiftOutCount <= shiftOutCount + 16'd1;
        end
    end
`else
    logic unusedBigShift;
    assign unusedBigShift = s2BigShift;
`endif

endmodule
